uart: RTL and testbench

Full-duplex 8N1 UART peripheral: one byte transmitter and one byte receiver sharing a system clock, with a simple strobe/flag handshake toward the CPU bus side. It sits between the peripheral bus glue (which drives `ss`/`data`/`rr` and reads `busy`/`rec_data`/`rec_valid`) and the board serial pins (`dout` = TX line, `din` = RX line). Default timing is 9600 baud from a 50 MHz clock.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx.sv | 103 ++++++++++
 rtl/uart.sv | 133 +++++++++++++
 tb/tb_uart.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART: FSM state encodings and bit-period math.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, glitch-filtered start detect, mid-bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic [7:0] data,
  output logic       done_c
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  rx_state_t       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic [7:0]      shift_nxt;
  logic            sync1, sync2;
  logic            bit_end_c, half_end_c;

  assign bit_end_c  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign half_end_c = (cnt == CW'(HALF - 1));

  // State, counters and synchronizer; line idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      data    <= 8'h00;
      sync1   <= 1'b1;
      sync2   <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      data    <= shift_nxt;
      sync1   <= din;
      sync2   <= sync1;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = data;
    done_c      = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!sync2) begin
          state_nxt = RX_START;
          cnt_nxt   = '0;
        end
      end
      RX_START: begin
        // A line that is high again at the half-bit point was only a glitch.
        if (half_end_c) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = sync2 ? RX_IDLE : RX_DATA;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (bit_end_c) begin
          cnt_nxt   = '0;
          shift_nxt = {sync2, data[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = RX_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (bit_end_c) begin
          cnt_nxt = '0;
          if (sync2) begin
            state_nxt = RX_IDLE;
            done_c    = 1'b1;
          end else begin
            state_nxt = RX_BREAK;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RX_BREAK: begin
        // Framing error: hold off until the line returns to idle.
        if (sync2) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART: inline transmitter, uart_rx receiver, rec_valid/rr handshake.
module uart
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  output logic       dout,
  input  logic       reset,
  input  logic       ss,
  input  logic [7:0] data,
  output logic       busy,
  output logic [7:0] rec_data,
  output logic       rec_valid,
  input  logic       din,
  input  logic       rr
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT);

  tx_state_t     tx_state, tx_state_nxt;
  logic [CW-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]    tx_bit, tx_bit_nxt;
  logic [7:0]    tx_shift, tx_shift_nxt;
  logic          dout_nxt, busy_nxt;
  logic          tx_bit_end_c;
  logic [7:0]    rx_data;
  logic          rx_done_c;

  assign tx_bit_end_c = (tx_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= 8'h00;
      dout     <= 1'b1;
      busy     <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      dout     <= dout_nxt;
      busy     <= busy_nxt;
    end
  end

  // dout/busy are computed one cycle ahead so the line changes exactly on bit boundaries.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    dout_nxt     = dout;
    busy_nxt     = busy;
    case (tx_state)
      TX_IDLE: begin
        dout_nxt = 1'b1;
        busy_nxt = 1'b0;
        if (ss) begin
          tx_state_nxt = TX_START;
          tx_cnt_nxt   = '0;
          tx_shift_nxt = data;
          dout_nxt     = 1'b0;
          busy_nxt     = 1'b1;
        end
      end
      TX_START: begin
        if (tx_bit_end_c) begin
          tx_state_nxt = TX_DATA;
          tx_cnt_nxt   = '0;
          tx_bit_nxt   = '0;
          dout_nxt     = tx_shift[0];
        end else begin
          tx_cnt_nxt = tx_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_bit_end_c) begin
          tx_cnt_nxt   = '0;
          tx_shift_nxt = {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) begin
            tx_state_nxt = TX_STOP;
            dout_nxt     = 1'b1;
          end else begin
            tx_bit_nxt = tx_bit + 3'd1;
            dout_nxt   = tx_shift[1];
          end
        end else begin
          tx_cnt_nxt = tx_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_bit_end_c) begin
          tx_state_nxt = TX_IDLE;
          tx_cnt_nxt   = '0;
          busy_nxt     = 1'b0;
        end else begin
          tx_cnt_nxt = tx_cnt + CW'(1);
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .data  (rx_data),
    .done_c(rx_done_c)
  );

  // A completing byte beats a simultaneous read and overwrites any unread byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_data  <= 8'h00;
      rec_valid <= 1'b0;
    end else if (rx_done_c) begin
      rec_data  <= rx_data;
      rec_valid <= 1'b1;
    end else if (rr) begin
      rec_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart at a shortened bit period, with a frame-level reference model.
module tb_uart;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       reset;
  logic       ss;
  logic [7:0] data;
  logic       rr;
  logic       din_drv;
  logic       loop_en;
  wire        din;
  wire        dout;
  wire        busy;
  wire  [7:0] rec_data;
  wire        rec_valid;

  int total = 0;
  int bad   = 0;

  assign din = loop_en ? dout : din_drv;

  uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .dout     (dout),
    .reset    (reset),
    .ss       (ss),
    .data     (data),
    .busy     (busy),
    .rec_data (rec_data),
    .rec_valid(rec_valid),
    .din      (din),
    .rr       (rr)
  );

  always #5 clk = ~clk;

  // Line level of bit slot idx (0 = start, 1..8 = data LSB first, 9 = stop) for byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return logic'((b >> (idx - 1)) & 8'h01);
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int k = 0; k < 10; k++) begin
      din_drv = (k == 9) ? stop : frame_bit(b, k);
      repeat (CPB) @(negedge clk);
    end
    din_drv = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ss = 1'b0; data = 8'h00; rr = 1'b0; din_drv = 1'b1; loop_en = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (dout !== 1'b1) begin bad++; $display("FAIL reset_dout got=%b want=1", dout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL reset_rec_valid got=%b want=0", rec_valid); end
    total++; if (rec_data !== 8'h00) begin bad++; $display("FAIL reset_rec_data got=%h want=00", rec_data); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic rx_check(input logic [7:0] b);
    send_frame(b, 1'b1);
    total++; if (rec_valid !== 1'b1) begin bad++; $display("FAIL rx_valid byte=%h got=%b want=1", b, rec_valid); end
    total++; if (rec_data !== b) begin bad++; $display("FAIL rx_data got=%h want=%h", rec_data, b); end
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL rx_rr_clear got=%b want=0", rec_valid); end
  endtask

  task automatic test_rx();
    rx_check(8'h48);
    for (int i = 0; i < 3; i++) rx_check(8'($urandom));
  endtask

  task automatic tx_frame(input logic [7:0] b, input logic inject);
    logic exp;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tx_idle_busy got=%b want=0", busy); end
    ss = 1'b1; data = b;
    @(negedge clk);
    ss = 1'b0; data = ~b;
    for (int k = 0; k < 10 * CPB; k++) begin
      exp = frame_bit(b, k / CPB);
      total++; if (dout !== exp) begin bad++; $display("FAIL tx_dout byte=%h cyc=%0d got=%b want=%b", b, k, dout, exp); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL tx_busy byte=%h cyc=%0d got=%b want=1", b, k, busy); end
      ss = (inject && k == 4 * CPB + 3);
      @(negedge clk);
    end
    ss = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tx_busy_fall byte=%h got=%b want=0", b, busy); end
    total++; if (dout !== 1'b1) begin bad++; $display("FAIL tx_dout_idle byte=%h got=%b want=1", b, dout); end
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tx_no_queue byte=%h got=%b want=0", b, busy); end
  endtask

  task automatic test_tx();
    tx_frame(8'hA5, 1'b1);
    for (int i = 0; i < 2; i++) tx_frame(8'($urandom), i == 0);
  endtask

  task automatic test_reset_midframe();
    ss = 1'b1; data = 8'($urandom);
    @(negedge clk);
    ss = 1'b0;
    repeat (3 * CPB + 5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    total++; if (dout !== 1'b1) begin bad++; $display("FAIL midreset_dout got=%b want=1", dout); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_glitch_framing();
    logic [7:0] good;
    din_drv = 1'b0;
    repeat (2) @(negedge clk);
    din_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b want=0", rec_valid); end
    good = 8'($urandom);
    rx_check(good);
    send_frame(8'($urandom), 1'b0);
    repeat (2 * CPB) @(negedge clk);
    total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL framing_valid got=%b want=0", rec_valid); end
    total++; if (rec_data !== good) begin bad++; $display("FAIL framing_data got=%h want=%h", rec_data, good); end
    rx_check(8'($urandom));
  endtask

  task automatic test_overrun_collision();
    logic [7:0] b3;
    logic seen;
    b3 = 8'($urandom);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    total++; if (rec_data !== 8'h22) begin bad++; $display("FAIL overrun_data got=%h want=22", rec_data); end
    total++; if (rec_valid !== 1'b1) begin bad++; $display("FAIL overrun_valid got=%b want=1", rec_valid); end
    seen = 1'b0;
    fork
      send_frame(b3, 1'b1);
      begin
        rr = 1'b1;
        @(negedge clk);
        total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL coll_rr_clear got=%b want=0", rec_valid); end
        for (int i = 0; i < 12 * CPB && !seen; i++) begin
          @(negedge clk);
          if (rec_valid) seen = 1'b1;
        end
        rr = 1'b0;
      end
    join
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL coll_timeout got=%b want=1", seen); end
    total++; if (rec_valid !== 1'b1) begin bad++; $display("FAIL coll_valid got=%b want=1", rec_valid); end
    total++; if (rec_data !== b3) begin bad++; $display("FAIL coll_data got=%h want=%h", rec_data, b3); end
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic [7:0] got [$];
    logic       prev_busy;
    int         accepted;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
    loop_en = 1'b1;
    accepted = 0;
    prev_busy = busy;
    data = bytes[0]; ss = 1'b1;
    for (int c = 0; c < 40 * CPB; c++) begin
      @(negedge clk);
      if (rr) rr = 1'b0;
      else if (rec_valid) begin got.push_back(rec_data); rr = 1'b1; end
      if (!prev_busy && busy) begin
        accepted++;
        if (accepted < 3) data = bytes[accepted];
        else ss = 1'b0;
      end
      prev_busy = busy;
      if (got.size() == 3 && !busy) break;
    end
    ss = 1'b0; rr = 1'b0;
    total++; if (accepted !== 3) begin bad++; $display("FAIL loop_frames got=%0d want=3", accepted); end
    total++; if (got.size() !== 3) begin bad++; $display("FAIL loop_count got=%0d want=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== bytes[i]) begin bad++; $display("FAIL loop_byte%0d got=%h want=%h", i, got[i], bytes[i]); end
      end
    end
    loop_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rx();
    test_tx();
    test_reset_midframe();
    test_glitch_framing();
    test_overrun_collision();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
